// File: rtl/photon_pkg.sv
// Shared PHOTON-80/20/16 definitions: geometry, round count, sequencer
// state encoding and the constant tables also used by the round datapath.
package photon_pkg;

  localparam int D       = 5;
  localparam int CELL_W  = 4;
  localparam int STATE_W = D * D * CELL_W;
  localparam int ROUNDS  = 12;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Round constants, one per round index.
  localparam logic [CELL_W-1:0] RC [ROUNDS] = '{
    4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h5, 4'hA
  };

  // Internal (per-row) constants added alongside RC.
  localparam logic [CELL_W-1:0] IC [D] = '{
    4'h0, 4'h1, 4'h3, 4'h6, 4'h4
  };

endpackage

// File: rtl/photon_perm_ctrl.sv
// Iterative PHOTON permutation sequencer: holds the state register and the
// round counter, feeds one external combinational round per clock and
// handles the producer/consumer handshakes.
module photon_perm_ctrl
  import photon_pkg::*;
#(
  parameter int STATE_W = photon_pkg::STATE_W,
  parameter int ROUNDS  = photon_pkg::ROUNDS,
  parameter int IDX_W   = photon_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               abort,
  output logic [STATE_W-1:0] rnd_state_o,
  output logic [IDX_W-1:0]   rnd_idx,
  input  logic [STATE_W-1:0] rnd_state_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  fsm_t               st;
  fsm_t               nxt;
  logic [STATE_W-1:0] state_q;
  logic [IDX_W-1:0]   cnt;
  logic               accept;
  logic               last_round;
  logic               kill;

  // accept only looks at the registered state, so in_ready never depends
  // on in_valid combinationally.
  assign accept     = in_valid && (st == IDLE);
  assign last_round = (cnt == IDX_W'(ROUNDS - 1));
  // abort is meaningful only once a permutation has started.
  assign kill       = abort && (st != IDLE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  // Next-state logic; abort outranks both the round update and out_ready.
  always_comb begin
    nxt = st;
    if (kill) begin
      nxt = IDLE;
    end else begin
      case (st)
        IDLE:    if (accept) nxt = RUN;
        RUN:     if (last_round) nxt = DONE;
        DONE:    if (out_ready) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Output decodes, all from the registered FSM state.
  always_comb begin
    in_ready  = (st == IDLE);
    busy      = (st == RUN);
    out_valid = (st == DONE);
  end

  // Round counter: cleared on start and abort, stops at ROUNDS-1 and
  // returns to 0 as the permutation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (kill) begin
      cnt <= '0;
    end else if (st == IDLE) begin
      if (accept) cnt <= '0;
    end else if (st == RUN) begin
      cnt <= last_round ? '0 : cnt + 1'b1;
    end
  end

  // State register: loaded on accept, replaced by the round result in RUN,
  // otherwise held (including across abort), so rnd_state_i is ignored
  // outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (!kill) begin
      if (accept)          state_q <= in_state;
      else if (st == RUN)  state_q <= rnd_state_i;
    end
  end

  assign rnd_state_o = state_q;
  assign rnd_idx     = cnt;
  assign out_state   = state_q;

endmodule
